tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz, integer multiple of 200.
REQ-002 The block SHALL have parameter CW, default 28, counter width in bits; 2^CW SHALL exceed CLK_HZ.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 = count continuously, 0 = hold.
REQ-006 step  input  1  one-cycle pulse; in IDLE/PAUSE run exactly one more period.
REQ-007 clr  input  1  one-cycle pulse; synchronous return to IDLE with counter cleared.
REQ-008 rate_sel  input  2  requested rate: 00=1 Hz, 01=2 Hz, 10=4 Hz, 11=100 Hz.
REQ-009 rate_load  input  1  one-cycle pulse; captures rate_sel as pending rate.
REQ-010 tick  output  1  registered one-cycle pulse at each period end.
REQ-011 half  output  1  registered square wave, high in second half of each period.
REQ-012 state  output  2  00=IDLE, 01=RUN, 10=PAUSE, 11=STEP.
REQ-013 rate_act  output  2  rate currently in use.
REQ-014 rate_pend  output  1  high while a loaded rate awaits application.

Function
REQ-015 The block SHALL derive DIV = CLK_HZ/rate for the active rate (CLK_HZ, CLK_HZ/2, CLK_HZ/4, CLK_HZ/100).
REQ-016 The block SHALL hold counter cnt in range 0..DIV-1, CW bits, never exceeding DIV-1.
REQ-017 In RUN and STEP, cnt SHALL increment by 1 per edge; at the edge where cnt==DIV-1, cnt SHALL become 0 and tick SHALL be 1 for the following cycle only.
REQ-018 In IDLE and PAUSE, cnt SHALL hold and tick SHALL be 0.
REQ-019 The edge that enters RUN or STEP SHALL NOT increment cnt; from IDLE, the first tick SHALL appear DIV cycles after that edge.
REQ-020 half SHALL equal (cnt >= DIV/2) as registered, and SHALL be 0 in IDLE.
REQ-021 Transitions: IDLE: run=1 -> RUN; step=1 -> STEP.
REQ-022 Transitions: RUN: run=0 -> PAUSE, holding cnt; step is ignored.
REQ-023 Transitions: PAUSE: run=1 -> RUN, resuming from the held cnt; step=1 -> STEP.
REQ-024 Transitions: STEP: on terminal count -> PAUSE, emitting one tick; run=1 before terminal count -> RUN, with the count continuing uninterrupted.
REQ-025 clr SHALL set state=IDLE, cnt=0, half=0, tick=0 and apply any pending rate, from any state.
REQ-026 Priority SHALL be clr > run > step when asserted in the same cycle.
REQ-027 rate_load SHALL set rate_pend=1 and store rate_sel; a later rate_load before application SHALL overwrite the stored value.
REQ-028 The pending rate SHALL apply at the next wrap edge (cnt DIV-1 -> 0), or immediately if state is IDLE; rate_pend SHALL clear on the same edge.
REQ-029 A rate_load coinciding with a wrap edge SHALL apply at that wrap, so the next period uses the new DIV.
REQ-030 A rate change SHALL never shorten or lengthen the period in progress, and SHALL NOT produce an extra or missing tick.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, cnt=0, tick=0, half=0, rate_act=00, rate_pend=0, pending rate=00, independent of clk.
REQ-032 After rst_n rises, the block SHALL respond to inputs from the first rising clk edge.
REQ-033 A reset asserted mid-period SHALL discard the partial count; no tick is generated.

Verification (CLK_HZ=1000: DIV=1000/500/250/10)
REQ-034 Reset, rate 11, run=1 held -> ticks 10 cycles after RUN entry, then every 10 cycles; half high on cycles where cnt=5..9.
REQ-035 Rate 11 running, pulse run=0 at cnt=4 for 20 cycles, then run=1 -> state PAUSE, no ticks; resume from cnt=4, next tick 6 cycles after resume edge.
REQ-036 In PAUSE, pulse step -> exactly one tick, state returns PAUSE; a second step -> one more full 10-cycle period.
REQ-037 Running at 01 (DIV=500), rate_load with 10 at cnt=100 -> rate_pend=1 for 399 cycles, current period completes at 500, next ticks every 250; rate_load on the wrap cycle -> new rate takes effect at that wrap.
REQ-038 clr and run asserted together while running -> IDLE, cnt=0, tick=0; rst_n pulsed low mid-period -> all outputs reset asynchronously, no tick.

Source files
------------

// File: rtl/tick_scheduler.sv
// Programmable tick generator: 1/2/4/100 Hz periods with run/pause/single-step control.
// Latency: tick and half are registered; tick is high the cycle after the terminal-count edge.
// Backpressure: none; inputs are sampled every clk edge, and clr has priority over run, which has priority over step.
//
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   run, step, clr      : run level, single-period step pulse, synchronous clear pulse
//   rate_sel, rate_load : requested rate (00=1Hz 01=2Hz 10=4Hz 11=100Hz) and its capture pulse
//   tick, half          : end-of-period pulse and second-half-of-period square wave
//   state               : 00=IDLE 01=RUN 10=PAUSE 11=STEP
//   rate_act, rate_pend : rate in use; a loaded rate is waiting for the next wrap
module tick_scheduler #(
  parameter int CLK_HZ = 50000000,
  parameter int CW     = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       clr,
  input  logic [1:0] rate_sel,
  input  logic       rate_load,
  output logic       tick,
  output logic       half,
  output logic [1:0] state,
  output logic [1:0] rate_act,
  output logic       rate_pend
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_STEP  = 2'b11
  } state_t;

  localparam logic [CW-1:0] DIV0 = CW'(CLK_HZ);
  localparam logic [CW-1:0] DIV1 = CW'(CLK_HZ / 2);
  localparam logic [CW-1:0] DIV2 = CW'(CLK_HZ / 4);
  localparam logic [CW-1:0] DIV3 = CW'(CLK_HZ / 100);

  state_t        st;
  logic [CW-1:0] cnt;
  logic [1:0]    rate_hold;

  logic [CW-1:0] div;
  logic [CW-1:0] div_m1;
  logic [CW-1:0] div_hf;
  logic [CW-1:0] cnt_inc;
  logic          counting;
  logic          at_term;
  logic          wrap;
  logic          eff_pend;
  logic [1:0]    eff_rate;
  logic          apply;

  assign state = st;

  // Period length for the rate currently in use.
  always_comb begin
    div = DIV0;
    case (rate_act)
      2'b00:   div = DIV0;
      2'b01:   div = DIV1;
      2'b10:   div = DIV2;
      default: div = DIV3;
    endcase
  end

  assign div_m1  = div - CW'(1);
  assign div_hf  = div >> 1;
  assign cnt_inc = cnt + CW'(1);

  // STEP keeps counting even when run takes it to RUN, so the period in
  // progress continues without a stall cycle.
  assign counting = ((st == S_RUN) && run) || (st == S_STEP);
  assign at_term  = (cnt == div_m1);
  assign wrap     = counting && at_term;

  // A rate_load on the same edge as a wrap (or in IDLE / under clr) is
  // applied directly, as if it had been pending already.
  assign eff_pend = rate_load | rate_pend;
  assign eff_rate = rate_load ? rate_sel : rate_hold;
  assign apply    = eff_pend && (clr || wrap || (st == S_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      cnt       <= '0;
      tick      <= 1'b0;
      half      <= 1'b0;
      rate_act  <= 2'b00;
      rate_pend <= 1'b0;
      rate_hold <= 2'b00;
    end else begin
      tick <= 1'b0;

      if (rate_load) begin
        rate_hold <= rate_sel;
      end

      if (apply) begin
        rate_act  <= eff_rate;
        rate_pend <= 1'b0;
      end else if (rate_load) begin
        rate_pend <= 1'b1;
      end

      if (clr) begin
        st   <= S_IDLE;
        cnt  <= '0;
        half <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (run)       st <= S_RUN;
            else if (step) st <= S_STEP;
          end
          S_RUN: begin
            if (!run)      st <= S_PAUSE;
          end
          S_PAUSE: begin
            if (run)       st <= S_RUN;
            else if (step) st <= S_STEP;
          end
          default: begin
            if (run)          st <= S_RUN;
            else if (at_term) st <= S_PAUSE;
          end
        endcase

        // Entering RUN/STEP from IDLE or PAUSE is not a counting edge, so
        // the first period out of IDLE is a full DIV cycles long.
        if (counting) begin
          if (at_term) begin
            cnt  <= '0;
            tick <= 1'b1;
            half <= 1'b0;
          end else begin
            cnt  <= cnt_inc;
            half <= (cnt_inc >= div_hf);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       clr;
  logic [1:0] rate_sel;
  logic       rate_load;
  logic       tick;
  logic       half;
  logic [1:0] state;
  logic [1:0] rate_act;
  logic       rate_pend;

  int checks = 0;
  int errors = 0;

  tick_scheduler #(.CLK_HZ(1000), .CW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .clr       (clr),
    .rate_sel  (rate_sel),
    .rate_load (rate_load),
    .tick      (tick),
    .half      (half),
    .state     (state),
    .rate_act  (rate_act),
    .rate_pend (rate_pend)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges until tick is seen (bounded); also counts samples with half high.
  task automatic wait_tick(input int max, output int n, output int nh);
    n  = 0;
    nh = 0;
    do begin
      tk();
      n++;
      if (half === 1'b1) nh++;
    end while (tick !== 1'b1 && n < max);
    if (tick !== 1'b1) n = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nh;
    int nt;

    rst_n = 1'b0; run = 1'b0; step = 1'b0; clr = 1'b0;
    rate_sel = 2'b00; rate_load = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_tick", tick, 0);
    chk("rst_half", half, 0);
    chk("rst_rate_act", rate_act, 0);
    chk("rst_pend", rate_pend, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 100 Hz loaded in IDLE applies at once
    rate_sel = 2'b11; rate_load = 1'b1;
    tk();
    rate_load = 1'b0;
    chk("idle_load_rate", rate_act, 3);
    chk("idle_load_pend", rate_pend, 0);
    chk("idle_state", state, 0);

    run = 1'b1;
    tk();
    chk("run_entry", state, 1);
    wait_tick(50, n, nh);
    chk("first_tick_lat", n, 10);
    chk("first_half_cycles", nh, 5);
    chk("half_at_wrap", half, 0);
    wait_tick(50, n, nh);
    chk("period_10", n, 10);

    // pause at cnt=4 for 20 cycles, then resume
    repeat (4) tk();
    run = 1'b0;
    tk();
    chk("pause_state", state, 2);
    nt = 0;
    repeat (20) begin
      tk();
      if (tick === 1'b1) nt++;
    end
    chk("pause_no_tick", nt, 0);
    chk("pause_half", half, 0);
    run = 1'b1;
    tk();
    chk("resume_state", state, 1);
    wait_tick(50, n, nh);
    chk("resume_tick_lat", n, 6);
    chk("resume_half_cycles", nh, 5);

    // single steps from PAUSE
    run = 1'b0;
    tk();
    chk("pause2_state", state, 2);
    step = 1'b1;
    tk();
    step = 1'b0;
    chk("step_state", state, 3);
    wait_tick(50, n, nh);
    chk("step_tick_lat", n, 10);
    chk("step_back_pause", state, 2);
    nt = 0;
    repeat (15) begin
      tk();
      if (tick === 1'b1) nt++;
    end
    chk("step_single_tick", nt, 0);
    step = 1'b1;
    tk();
    step = 1'b0;
    wait_tick(50, n, nh);
    chk("step2_tick_lat", n, 10);
    chk("step2_back_pause", state, 2);

    // clr applies a same-cycle rate_load (2 Hz, DIV=500)
    clr = 1'b1; rate_sel = 2'b01; rate_load = 1'b1;
    tk();
    clr = 1'b0; rate_load = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_rate_apply", rate_act, 1);
    chk("clr_pend", rate_pend, 0);

    run = 1'b1;
    tk();
    repeat (100) tk();
    rate_sel = 2'b10; rate_load = 1'b1;
    tk();
    rate_load = 1'b0;
    chk("pend_set", rate_pend, 1);
    chk("rate_unchanged", rate_act, 1);
    n = 1;
    while (rate_pend === 1'b1 && n < 1000) begin
      tk();
      if (rate_pend === 1'b1) n++;
    end
    chk("pend_cycles", n, 399);
    chk("wrap_tick", tick, 1);
    chk("rate_applied", rate_act, 2);
    wait_tick(600, n, nh);
    chk("div250_lat", n, 250);
    chk("div250_half", nh, 125);

    // rate_load on the wrap edge takes effect at that wrap
    repeat (249) tk();
    rate_sel = 2'b11; rate_load = 1'b1;
    tk();
    rate_load = 1'b0;
    chk("wrap_load_tick", tick, 1);
    chk("wrap_load_rate", rate_act, 3);
    chk("wrap_load_pend", rate_pend, 0);
    wait_tick(50, n, nh);
    chk("wrap_load_lat", n, 10);

    // clr wins over run
    repeat (3) tk();
    clr = 1'b1;
    tk();
    clr = 1'b0;
    chk("clr_run_state", state, 0);
    chk("clr_run_tick", tick, 0);
    chk("clr_run_half", half, 0);
    tk();
    chk("rerun_state", state, 1);
    wait_tick(50, n, nh);
    chk("rerun_lat", n, 10);

    // asynchronous reset mid-period
    repeat (7) tk();
    chk("mid_half", half, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_half", half, 0);
    chk("arst_tick", tick, 0);
    chk("arst_rate_act", rate_act, 0);
    chk("arst_pend", rate_pend, 0);
    nt = 0;
    repeat (3) begin
      tk();
      if (tick === 1'b1 || state !== 2'b00) nt++;
    end
    chk("arst_hold", nt, 0);
    rst_n = 1'b1;
    tk();
    chk("post_rst_run", state, 1);
    wait_tick(1100, n, nh);
    chk("div1000_lat", n, 1000);
    chk("div1000_half", nh, 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
